// File: rtl/enemy_scheduler.sv
// ---------------------------------------------------------------------------
// enemy_scheduler
//
// Purpose:
//   Game-flow sequencer for a group of enemies. After a game start it walks
//   through the enemies and gives each one a one-cycle start pulse, spaced
//   SPAWN_DELAY clocks apart. It then waits in PLAY for any enemy to report
//   a collision. A collision costs one life. With lives remaining, all enemies
//   are held in reset for RESPAWN_DELAY clocks and then re-sequenced.
//   Otherwise the game ends in OVER until the next game_start.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   game_start   in   level request to begin/restart a game (IDLE/OVER only)
//   death_in     in   [N_ENEMY] per-enemy collision flags
//   enemy_rst    out  [N_ENEMY] per-enemy reset, all-ones outside SPAWN/PLAY
//   enemy_start  out  [N_ENEMY] one-cycle start pulse per enemy
//   lives_left   out  [2] remaining lives
//   player_hit   out  one-cycle pulse per accepted hit
//   game_over    out  high while in OVER
//   sched_state  out  [3] current FSM state (IDLE=0 .. OVER=5)
//
// Configuration macro:
//   ENEMY_SCHED_SPAWN_GRACE_EN - when defined, collisions are ignored while
//   enemies are being spawned. When undefined, a collision in SPAWN is
//   accepted exactly as in PLAY.
//
// Every output is a register. Each output register is loaded from the
// *next* state, so it stays cycle-aligned with sched_state.
// ---------------------------------------------------------------------------
module enemy_scheduler #(
   parameter int N_ENEMY       = 4,
   parameter int SPAWN_DELAY   = 1400000,
   parameter int RESPAWN_DELAY = 2000000,
   parameter int LIVES         = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               game_start,
   input  logic [N_ENEMY-1:0] death_in,
   output logic [N_ENEMY-1:0] enemy_rst,
   output logic [N_ENEMY-1:0] enemy_start,
   output logic [1:0]         lives_left,
   output logic               player_hit,
   output logic               game_over,
   output logic [2:0]         sched_state
);

   localparam int CW = 21;
   localparam int IW = (N_ENEMY > 1) ? $clog2(N_ENEMY) : 1;

   localparam logic [CW-1:0] SPAWN_LAST   = CW'(SPAWN_DELAY - 1);
   localparam logic [CW-1:0] RESPAWN_LAST = CW'(RESPAWN_DELAY - 1);
   localparam logic [IW-1:0] IDX_LAST     = IW'(N_ENEMY - 1);
   localparam logic [1:0]    LIVES_INIT   = 2'(LIVES);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SPAWN   = 3'd1,
      S_PLAY    = 3'd2,
      S_HIT     = 3'd3,
      S_RESPAWN = 3'd4,
      S_OVER    = 3'd5
   } state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic [1:0]         lives_q, lives_d;
   logic [N_ENEMY-1:0] start_q, start_d;
   logic [N_ENEMY-1:0] erst_q, erst_d;
   logic               hit_q, hit_d;
   logic               over_q, over_d;
   logic               any_death;
   logic               spawn_hit;
   logic [1:0]         lives_dec;

   assign any_death = |death_in;
   // Saturating decrement, so lives can never underflow.
   assign lives_dec = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;

`ifdef ENEMY_SCHED_SPAWN_GRACE_EN
   assign spawn_hit = 1'b0;
`else
   assign spawn_hit = any_death;
`endif

   // Next-state logic and the values of the registered outputs.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      lives_d = lives_q;

      case (state_q)
         S_IDLE, S_OVER: begin
            if (game_start) begin
               state_d = S_SPAWN;
               cnt_d   = '0;
               idx_d   = '0;
               lives_d = LIVES_INIT;
            end
         end
         S_SPAWN: begin
            if (spawn_hit) begin
               // Take the life on entry to HIT, so lives_left already shows
               // the new count while player_hit is high.
               state_d = S_HIT;
               cnt_d   = '0;
               lives_d = lives_dec;
            end else if (cnt_q == SPAWN_LAST) begin
               cnt_d = '0;
               if (idx_q == IDX_LAST) begin
                  state_d = S_PLAY;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_PLAY: begin
            if (any_death) begin
               state_d = S_HIT;
               cnt_d   = '0;
               lives_d = lives_dec;
            end
         end
         S_HIT: begin
            cnt_d   = '0;
            state_d = (lives_q == 2'd0) ? S_OVER : S_RESPAWN;
         end
         S_RESPAWN: begin
            if (cnt_q == RESPAWN_LAST) begin
               state_d = S_SPAWN;
               cnt_d   = '0;
               idx_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
         end
      endcase

      // The start pulse fires in the first cycle of each enemy's slot.
      for (int i = 0; i < N_ENEMY; i++) begin
         start_d[i] = (state_d == S_SPAWN) && (cnt_d == '0) && (idx_d == IW'(i));
      end
      erst_d = ((state_d == S_SPAWN) || (state_d == S_PLAY)) ? '0 : '1;
      hit_d  = (state_d == S_HIT);
      over_d = (state_d == S_OVER);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         lives_q <= 2'd0;
         start_q <= '0;
         erst_q  <= '1;
         hit_q   <= 1'b0;
         over_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         lives_q <= lives_d;
         start_q <= start_d;
         erst_q  <= erst_d;
         hit_q   <= hit_d;
         over_q  <= over_d;
      end
   end

   assign enemy_rst   = erst_q;
   assign enemy_start = start_q;
   assign lives_left  = lives_q;
   assign player_hit  = hit_q;
   assign game_over   = over_q;
   assign sched_state = state_q;

endmodule

// File: tb/tb_enemy_scheduler.sv
// ---------------------------------------------------------------------------
// tb_enemy_scheduler
//
// Directed bench for enemy_scheduler with N_ENEMY=2, SPAWN_DELAY=4,
// RESPAWN_DELAY=3 and LIVES=2. Inputs change 1 ns after a rising edge.
// Outputs are checked at the same moment, after the registers have settled.
// All expected values are worked out by hand from the state sequence.
// ---------------------------------------------------------------------------
module tb_enemy_scheduler;

   localparam int N = 2;

   logic         clk;
   logic         reset;
   logic         game_start;
   logic [N-1:0] death_in;
   logic [N-1:0] enemy_rst;
   logic [N-1:0] enemy_start;
   logic [1:0]   lives_left;
   logic         player_hit;
   logic         game_over;
   logic [2:0]   sched_state;

   int checks   = 0;
   int failures = 0;
   int hit_count = 0;

   enemy_scheduler #(
      .N_ENEMY(2), .SPAWN_DELAY(4), .RESPAWN_DELAY(3), .LIVES(2)
   ) dut (
      .clk(clk), .reset(reset), .game_start(game_start), .death_in(death_in),
      .enemy_rst(enemy_rst), .enemy_start(enemy_start), .lives_left(lives_left),
      .player_hit(player_hit), .game_over(game_over), .sched_state(sched_state)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count player_hit pulses, sampled mid-cycle.
   always @(negedge clk) begin
      if (!reset && player_hit === 1'b1) hit_count++;
   end

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset      = 1'b1;
      game_start = 1'b0;
      death_in   = '0;
      tick(3);
      reset = 1'b0;
      check("rst_state", 32'(sched_state), 32'd0);
      check("rst_erst",  32'(enemy_rst),   32'h3);
      check("rst_start", 32'(enemy_start), 32'h0);
      check("rst_lives", 32'(lives_left),  32'd0);
      check("rst_over",  32'(game_over),   32'd0);
      check("rst_hit",   32'(player_hit),  32'd0);

      // Start, then reset partway through SPAWN.
      game_start = 1'b1;
      tick(1);
      game_start = 1'b0;
      check("s0_state", 32'(sched_state), 32'd1);
      check("s0_lives", 32'(lives_left),  32'd2);
      tick(2);
      reset = 1'b1;
      tick(1);
      check("midrst_state", 32'(sched_state), 32'd0);
      check("midrst_erst",  32'(enemy_rst),   32'h3);
      check("midrst_start", 32'(enemy_start), 32'h0);
      check("midrst_lives", 32'(lives_left),  32'd0);
      reset = 1'b0;
      tick(1);
      check("idle_hold", 32'(sched_state), 32'd0);

      // Full spawn sequence: starts at +0 and +4, PLAY at +8.
      game_start = 1'b1;
      tick(1);
      game_start = 1'b0;
      check("sp_state0", 32'(sched_state), 32'd1);
      check("sp_start0", 32'(enemy_start), 32'h1);
      check("sp_erst0",  32'(enemy_rst),   32'h0);
      tick(1);
      check("sp_start1", 32'(enemy_start), 32'h0);
      tick(3);
      check("sp_start4", 32'(enemy_start), 32'h2);
      check("sp_state4", 32'(sched_state), 32'd1);
      tick(3);
      check("sp_state7", 32'(sched_state), 32'd1);
      check("sp_start7", 32'(enemy_start), 32'h0);
      tick(1);
      check("play_state", 32'(sched_state), 32'd2);
      check("play_erst",  32'(enemy_rst),   32'h0);
      check("play_start", 32'(enemy_start), 32'h0);

      // game_start is ignored in PLAY.
      game_start = 1'b1;
      tick(1);
      game_start = 1'b0;
      check("play_gs_ign", 32'(sched_state), 32'd2);

      // Both enemies hit for 5 cycles: one hit, then RESPAWN for 3 cycles.
      death_in = 2'b11;
      tick(1);
      check("hit_state", 32'(sched_state), 32'd3);
      check("hit_pulse", 32'(player_hit),  32'd1);
      check("hit_lives", 32'(lives_left),  32'd1);
      check("hit_erst",  32'(enemy_rst),   32'h3);
      tick(1);
      check("rsp0_state", 32'(sched_state), 32'd4);
      check("rsp0_hit",   32'(player_hit),  32'd0);
      game_start = 1'b1;
      tick(1);
      game_start = 1'b0;
      check("rsp1_state", 32'(sched_state), 32'd4);
      tick(1);
      check("rsp2_state", 32'(sched_state), 32'd4);
      tick(1);
      death_in = 2'b00;
      check("respawn_sp",    32'(sched_state), 32'd1);
      check("respawn_start", 32'(enemy_start), 32'h1);
      check("respawn_lives", 32'(lives_left),  32'd1);
      check("one_hit",       32'(hit_count),   32'd1);

      // Collision during SPAWN.
      death_in = 2'b01;
      tick(1);
`ifdef ENEMY_SCHED_SPAWN_GRACE_EN
      death_in = 2'b00;
      check("grace_state", 32'(sched_state), 32'd1);
      tick(7);
      check("grace_play", 32'(sched_state), 32'd2);
      death_in = 2'b01;
      tick(1);
`endif
      death_in = 2'b00;
      check("hit2_state", 32'(sched_state), 32'd3);
      check("hit2_lives", 32'(lives_left),  32'd0);
      tick(1);
      check("over_state", 32'(sched_state), 32'd5);
      check("over_flag",  32'(game_over),   32'd1);

      // OVER ignores further collisions.
      death_in = 2'b11;
      tick(2);
      death_in = 2'b00;
      check("over_hold",  32'(sched_state), 32'd5);
      check("over_flag2", 32'(game_over),   32'd1);
      check("over_lives", 32'(lives_left),  32'd0);
      check("two_hits",   32'(hit_count),   32'd2);

      // Restart from OVER.
      game_start = 1'b1;
      tick(1);
      game_start = 1'b0;
      check("restart_state", 32'(sched_state), 32'd1);
      check("restart_lives", 32'(lives_left),  32'd2);
      check("restart_over",  32'(game_over),   32'd0);
      check("restart_start", 32'(enemy_start), 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/enemy_scheduler.md
ENEMY_SCHEDULER -- requirements
Module: enemy_scheduler

Interface
REQ-001 SHALL have parameter N_ENEMY, default 4: number of enemy instances sequenced (1..8).
REQ-002 SHALL have parameter SPAWN_DELAY, default 1400000: clk cycles between successive enemy start pulses (2..2^21-1).
REQ-003 SHALL have parameter RESPAWN_DELAY, default 2000000: clk cycles held in RESPAWN after a hit (1..2^21-1).
REQ-004 SHALL have parameter LIVES, default 3: player lives at game start (1..3).
REQ-005 SHALL have port clk  input  1  system clock; reset reset, asynchronous, active-high; clock clk.
REQ-006 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-007 SHALL have port game_start  input  1  level request to begin/restart a game.
REQ-008 SHALL have port death_in  input  N_ENEMY  per-enemy collision flag (one bit per enemy death_signal).
REQ-009 SHALL have port enemy_rst  output  N_ENEMY  per-enemy reset (reloads spawn position, forces enemy Idle).
REQ-010 SHALL have port enemy_start  output  N_ENEMY  one-cycle start pulse per enemy.
REQ-011 SHALL have port lives_left  output  2  remaining lives.
REQ-012 SHALL have port player_hit  output  1  one-cycle pulse on each accepted hit.
REQ-013 SHALL have port game_over  output  1  high while in OVER.
REQ-014 SHALL have port sched_state  output  3  current FSM state encoding (debug/top-level use).

Function
REQ-015 SHALL implement FSM states IDLE=0, SPAWN=1, PLAY=2, HIT=3, RESPAWN=4, OVER=5; all outputs registered.
REQ-016 IDLE: on game_start=1 SHALL load lives_left<=LIVES, clear counter and index, go SPAWN.
REQ-017 SPAWN: 21-bit counter SHALL count 0..SPAWN_DELAY-1; at counter==0 SHALL pulse enemy_start[idx] for exactly one cycle.
REQ-018 SPAWN: at counter==SPAWN_DELAY-1 counter SHALL wrap to 0 and idx increment; at wrap with idx==N_ENEMY-1 SHALL go PLAY.
REQ-019 PLAY: if any death_in bit is 1, SHALL go HIT next cycle; enemy_start SHALL be 0 throughout PLAY.
REQ-020 HIT (one cycle): SHALL pulse player_hit, decrement lives_left; if resulting lives_left==0 go OVER, else go RESPAWN with counter cleared.
REQ-021 RESPAWN: SHALL hold RESPAWN_DELAY cycles, then clear idx/counter and go SPAWN.
REQ-022 OVER: game_over=1; on game_start=1 SHALL behave exactly as IDLE with game_start (reload lives, go SPAWN).
REQ-023 enemy_rst SHALL be all-ones in IDLE, HIT, RESPAWN, OVER and all-zeros in SPAWN, PLAY.
REQ-024 death_in SHALL be ignored in IDLE, HIT, RESPAWN, OVER; multiple simultaneous death_in bits SHALL count as one hit.
REQ-025 game_start SHALL be ignored in SPAWN, PLAY, HIT, RESPAWN.
REQ-026 lives_left SHALL never underflow below 0; counter SHALL never exceed max(SPAWN_DELAY,RESPAWN_DELAY)-1.
REQ-027 Illegal sched_state encodings SHALL return to IDLE next cycle.

Reset
REQ-028 On reset=1 (any time, including mid-SPAWN or mid-RESPAWN): state=IDLE, counter=0, idx=0, lives_left=0, enemy_start=0, player_hit=0, game_over=0, enemy_rst=all-ones.
REQ-029 First transition out of IDLE SHALL occur no earlier than the first clk edge after reset deasserts.

Configuration
REQ-030 Macro ENEMY_SCHED_SPAWN_GRACE_EN: when defined, death_in SHALL also be ignored in SPAWN (player invulnerable while enemies enter); when undefined, a death_in during SPAWN SHALL go to HIT next cycle exactly as in PLAY.

Verification (N_ENEMY=2, SPAWN_DELAY=4, RESPAWN_DELAY=3, LIVES=2)
REQ-031 Reset mid-SPAWN -> next cycle sched_state=0, enemy_rst=2'b11, enemy_start=0, lives_left=0.
REQ-032 game_start in IDLE -> enemy_start=01 on first SPAWN cycle, 10 four cycles later, sched_state=2 eight cycles after SPAWN entry, enemy_rst=00.
REQ-033 PLAY, death_in=2'b11 for 5 cycles -> exactly one player_hit pulse, lives_left 2->1, RESPAWN 3 cycles, then SPAWN re-entered with enemy_start=01.
REQ-034 Second hit with lives_left=1 -> lives_left=0, sched_state=5, game_over=1 held; further death_in has no effect; game_start -> lives_left=2, SPAWN.
REQ-035 death_in=01 during SPAWN -> HIT next cycle without macro; with ENEMY_SCHED_SPAWN_GRACE_EN no hit, PLAY reached on schedule.
REQ-036 game_start pulsed during PLAY/RESPAWN -> no state change, counters unaffected.
